// File: rtl/seq_detect_multi.sv
// Multi-channel serial pattern detector: per-channel shift register, fill tracking,
// registered match pulse, armed flag and saturating match counter.
module seq_detect_multi #(
  parameter int               CHANNELS = 2,
  parameter int               LEN      = 4,
  parameter logic [LEN-1:0]   PATTERN  = 4'b1101,
  parameter int               OVERLAP  = 1,
  parameter int               COUNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [CHANNELS-1:0]         a,
  input  logic                        clr,
  output logic [CHANNELS-1:0]         out1,
  output logic [CHANNELS-1:0]         out2,
  output logic [CHANNELS*COUNT_W-1:0] count
);

  localparam int             FW    = $clog2(LEN + 1);
  localparam logic [FW:0]    LEN_X = (FW+1)'(LEN);
  localparam logic [FW-1:0]  LEN_F = FW'(LEN);

  typedef enum logic {
    ST_FILL,
    ST_ARMED
  } state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [LEN-1:0]     r_sh;
    logic [FW-1:0]      r_fill;
    logic [COUNT_W-1:0] r_cnt;
    logic               r_out1;

    state_t             w_state;
    logic [LEN-1:0]     w_nsh;
    logic [FW:0]        w_fill_inc;
    logic               w_hit;
    logic [LEN-1:0]     w_sh_nxt;
    logic [FW-1:0]      w_fill_nxt;
    logic [COUNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sh   <= '0;
        r_fill <= '0;
        r_cnt  <= '0;
        r_out1 <= 1'b0;
      end else begin
        r_sh   <= w_sh_nxt;
        r_fill <= w_fill_nxt;
        r_cnt  <= w_cnt_nxt;
        r_out1 <= w_hit;
      end
    end

    // The fill counter is the state register; FILL/ARMED is decoded from it.
    always_comb begin
      w_state    = (r_fill == LEN_F) ? ST_ARMED : ST_FILL;
      w_nsh      = {r_sh[LEN-2:0], a[c]};
      w_fill_inc = {1'b0, r_fill} + (FW+1)'(1);
      w_hit      = en && (w_nsh == PATTERN) && (w_fill_inc >= LEN_X);
      w_sh_nxt   = r_sh;
      w_fill_nxt = r_fill;
      w_cnt_nxt  = r_cnt;

      if (en) begin
        w_sh_nxt = w_nsh;
        if (w_hit && (OVERLAP == 0))
          w_fill_nxt = '0;
        else if (w_state == ST_FILL)
          w_fill_nxt = w_fill_inc[FW-1:0];
      end

      if (clr)
        w_cnt_nxt = '0;
      else if (w_hit && (r_cnt != '1))
        w_cnt_nxt = r_cnt + COUNT_W'(1);
    end

    assign out1[c]                       = r_out1;
    assign out2[c]                       = (w_state == ST_ARMED);
    assign count[c*COUNT_W +: COUNT_W]   = r_cnt;
  end

endmodule

// File: tb/tb_seq_detect_multi.sv
// Bench for seq_detect_multi: three configurations driven in parallel and checked
// against a sample-history reference model, plus directed boundary checks.
module tb_seq_detect_multi;

  logic        clk = 1'b0;
  logic        rst_n, en, clr;
  logic [1:0]  a;
  logic [1:0]  a_o1, a_o2, b_o1, b_o2, c_o1, c_o2;
  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  c_cnt;

  seq_detect_multi #(.CHANNELS(2), .LEN(4), .PATTERN(4'b1101), .OVERLAP(1), .COUNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .clr(clr),
    .out1(a_o1), .out2(a_o2), .count(a_cnt));

  seq_detect_multi #(.CHANNELS(2), .LEN(4), .PATTERN(4'b1101), .OVERLAP(0), .COUNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .clr(clr),
    .out1(b_o1), .out2(b_o2), .count(b_cnt));

  seq_detect_multi #(.CHANNELS(2), .LEN(4), .PATTERN(4'b1111), .OVERLAP(1), .COUNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .clr(clr),
    .out1(c_o1), .out2(c_o2), .count(c_cnt));

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  string phase = "reset";

  int pat  [3] = '{13, 13, 15};
  int ov   [3] = '{1, 0, 1};
  int cmax [3] = '{255, 255, 3};
  int cw   [3] = '{8, 8, 2};

  int m_fresh [3][2];
  int m_cnt   [3][2];
  bit m_o1    [3][2];
  bit hist    [2][$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s %s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 2; c++) begin
        m_fresh[d][c] = 0;
        m_cnt[d][c]   = 0;
        m_o1[d][c]    = 1'b0;
      end
    for (int c = 0; c < 2; c++) hist[c].delete();
  endtask

  task automatic model_step(input logic [1:0] ai, input logic ei, input logic ci);
    if (ei)
      for (int c = 0; c < 2; c++) begin
        hist[c].push_back(ai[c]);
        if (hist[c].size() > 8) void'(hist[c].pop_front());
      end
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 2; c++) begin
        bit hit;
        int win;
        hit = 1'b0;
        if (ei && hist[c].size() >= 4) begin
          win = 0;
          for (int i = 0; i < 4; i++)
            win = win * 2 + int'(hist[c][hist[c].size() - 4 + i]);
          hit = (m_fresh[d][c] + 1 >= 4) && (win == pat[d]);
        end
        if (ei) begin
          if (hit && ov[d] == 0) m_fresh[d][c] = 0;
          else if (m_fresh[d][c] < 4) m_fresh[d][c]++;
        end
        m_o1[d][c] = hit;
        if (ci) m_cnt[d][c] = 0;
        else if (hit && m_cnt[d][c] < cmax[d]) m_cnt[d][c]++;
      end
  endtask

  task automatic check_all();
    logic [15:0] o1 [3];
    logic [15:0] o2 [3];
    logic [15:0] oc [3];
    logic [15:0] e1, e2, ec;
    o1[0] = {14'b0, a_o1}; o2[0] = {14'b0, a_o2}; oc[0] = a_cnt;
    o1[1] = {14'b0, b_o1}; o2[1] = {14'b0, b_o2}; oc[1] = b_cnt;
    o1[2] = {14'b0, c_o1}; o2[2] = {14'b0, c_o2}; oc[2] = {12'b0, c_cnt};
    for (int d = 0; d < 3; d++) begin
      e1 = '0; e2 = '0; ec = '0;
      for (int c = 0; c < 2; c++) begin
        e1[c] = m_o1[d][c];
        e2[c] = (m_fresh[d][c] >= 4);
        if (cw[d] == 8) ec[c*8 +: 8] = 8'(m_cnt[d][c]);
        else            ec[c*2 +: 2] = 2'(m_cnt[d][c]);
      end
      chk($sformatf("dut%0d out1", d), o1[d], e1);
      chk($sformatf("dut%0d out2", d), o2[d], e2);
      chk($sformatf("dut%0d count", d), oc[d], ec);
    end
  endtask

  task automatic step(input logic [1:0] ai, input logic ei, input logic ci);
    a = ai; en = ei; clr = ci;
    @(posedge clk);
    model_step(ai, ei, ci);
    #1;
    check_all();
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic do_reset();
    en = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    #3 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = 2'b00;
    model_reset();
    #3 check_all();
    #9 rst_n = 1'b1;

    phase = "fill_indep";
    step(2'b11, 1'b1, 1'b0);
    chk("out2 after s1", {14'b0, a_o2}, 16'h0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    chk("out2 after s3", {14'b0, a_o2}, 16'h0);
    step(2'b11, 1'b1, 1'b0);
    chk("out1 after s4", {14'b0, a_o1}, 16'h1);
    chk("out2 after s4", {14'b0, a_o2}, 16'h3);
    chk("cnt after s4", a_cnt, 16'h0001);

    phase = "overlap";
    step(2'b01, 1'b1, 1'b0);
    chk("ov0 out2 drop", {14'b0, b_o2}, 16'h2);
    step(2'b00, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    chk("ov1 cnt after s7", {8'h0, a_cnt[7:0]}, 16'h0002);
    chk("ov0 cnt after s7", {8'h0, b_cnt[7:0]}, 16'h0001);
    step(2'b00, 1'b1, 1'b0);
    chk("ov0 out2 rearm", {15'b0, b_o2[0]}, 16'h1);

    phase = "en_gap";
    do_reset();
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b0, 1'b0);
      chk("no pulse in gap", {14'b0, a_o1}, 16'h0);
    end
    step(2'b00, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    chk("gap pulse", {14'b0, a_o1}, 16'h1);
    chk("gap cnt", a_cnt, 16'h0001);

    phase = "saturate";
    do_reset();
    for (int i = 0; i < 8; i++) step(2'b01, 1'b1, 1'b0);
    chk("sat cnt", {12'b0, c_cnt}, 16'h0003);
    step(2'b01, 1'b1, 1'b1);
    chk("clr vs hit out1", {14'b0, c_o1}, 16'h1);
    chk("clr vs hit cnt", {12'b0, c_cnt}, 16'h0000);

    phase = "mid_reset";
    do_reset();
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    do_reset();
    step(2'b01, 1'b1, 1'b0);
    chk("no match after rst", {14'b0, a_o1}, 16'h0);
    chk("fill restarted", {14'b0, a_o2}, 16'h0);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      logic [1:0] ra;
      logic       re, rc;
      ra = 2'($urandom_range(0, 3));
      re = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 19) == 0);
      step(ra, re, rc);
      if (i % 137 == 136) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
